seq_pattern_gen: RTL and testbench

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_piso.sv | 54 +++++
 rtl/seq_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the serial pattern generator:
//   - default parameter values for pattern, repeat and gap widths
//   - the controller state type
package seq_pkg;

  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

  // All four 2-bit codes are assigned, so no code is unreachable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_piso.sv
// seq_piso
// Parallel-in, serial-out shift register. Data leaves MSB first, and zeros
// enter at the LSB.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (clears the register)
//   i_load      load i_din (takes priority over shift)
//   i_shift     shift left by one
//   i_clear     clear to zero (highest priority after rst)
//   i_din       parallel load data
//   o_msb_next  MSB of the value the register takes at the next edge. The
//               parent registers it, so the serial bit is timed with its state.
module seq_piso #(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic [PAT_W-1:0] i_din,
  output logic             o_msb_next
);

  logic [PAT_W-1:0] r_q;
  logic [PAT_W-1:0] w_shifted;
  logic [PAT_W-1:0] w_q_next;

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign w_shifted[gi] = 1'b0;
      end else begin : g_bit
        assign w_shifted[gi] = r_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    w_q_next = r_q;
    if (i_clear)      w_q_next = '0;
    else if (i_load)  w_q_next = i_din;
    else if (i_shift) w_q_next = w_shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= w_q_next;
  end

  assign o_msb_next = w_q_next[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Sends a PAT_W-bit pattern MSB first, repeat_n times. Each repetition after
// the first is preceded by gap idle cycles.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      request a transmission; sampled only while ready=1
//   abort      end the current transmission without a done pulse
//   pattern    bit pattern, captured on start acceptance
//   repeat_n   repetition count, captured on start acceptance
//   gap        idle cycles between repetitions, captured on start acceptance
//   o          serial data bit; 0 whenever o_valid=0
//   o_valid    o carries a pattern bit this cycle
//   ready      idle and able to accept start
//   done       one-cycle pulse after the last bit of the last repetition
// Every output comes from a flop loaded from next-state decode.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             o,
  output logic             o_valid,
  output logic             ready,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_rep_cnt;    // repetitions still to send, including the current one
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;    // idle cycles left in the current gap
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_o;
  logic             r_o_valid;
  logic             r_ready;
  logic             r_done;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_load;
  logic             w_shift;
  logic             w_clear;
  logic [PAT_W-1:0] w_load_data;
  logic             w_msb_next;

  assign w_accept   = (r_state == ST_IDLE) && start && !abort;
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_state_next = ST_IDLE;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_load_data  = r_pat;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // The first repetition loads straight from the port. Later ones
          // reload from the captured copy.
          w_load_data  = pattern;
          w_load       = 1'b1;
          w_state_next = (repeat_n != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_clear = 1'b1;
        end else if (w_last_bit) begin
          if (r_rep_cnt == CNT_W'(1)) begin
            w_state_next = ST_DONE;
            w_clear      = 1'b1;
          end else if (r_gap != '0) begin
            w_state_next = ST_GAP;
            w_clear      = 1'b1;
          end else begin
            // With no gap, the next MSB follows this LSB directly.
            w_state_next = ST_SHIFT;
            w_load       = 1'b1;
          end
        end else begin
          w_state_next = ST_SHIFT;
          w_shift      = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_clear = 1'b1;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_state_next = ST_SHIFT;
          w_load       = 1'b1;
        end else begin
          w_state_next = ST_GAP;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: begin
        w_state_next = ST_IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  seq_piso #(.PAT_W(PAT_W)) u_piso (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_clear    (w_clear),
    .i_din      (w_load_data),
    .o_msb_next (w_msb_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_rep_cnt <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_bit_cnt <= '0;
      r_o       <= 1'b0;
      r_o_valid <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pat     <= pattern;
            r_rep_cnt <= repeat_n;
            r_gap     <= gap;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!abort) begin
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_rep_cnt <= r_rep_cnt - CNT_W'(1);
              r_gap_cnt <= r_gap;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (!abort) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
      r_o_valid <= (w_state_next == ST_SHIFT);
      r_o       <= (w_state_next == ST_SHIFT) && w_msb_next;
      r_done    <= (w_state_next == ST_DONE);
      r_ready   <= (w_state_next == ST_IDLE);
    end
  end

  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign ready   = r_ready;
  assign done    = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen
// Directed bench with a cycle-accurate scoreboard. Each step pushes the
// expected {o_valid, o, done, ready} for every cycle after the driving edge.
// A monitor pops one entry per cycle, #1 after the rising edge, and compares.
module tb_seq_pattern_gen;
  import seq_pkg::*;

  localparam int PW = PAT_W_DEF;
  localparam int CW = CNT_W_DEF;
  localparam int GW = GAP_W_DEF;

  typedef struct packed {
    logic v;
    logic o;
    logic d;
    logic r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [PW-1:0] pattern;
  logic [CW-1:0] repeat_n;
  logic [GW-1:0] gap;
  logic          o;
  logic          o_valid;
  logic          ready;
  logic          done;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string tag    = "reset";
  int    idx    = 0;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap      (gap),
    .o        (o),
    .o_valid  (o_valid),
    .ready    (ready),
    .done     (done)
  );

  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t got;
    #1;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      got = {o_valid, o, done, ready};
      checks++;
      assert (got === e)
      else begin
        errors++;
        $error("FAIL %s[%0d] observed v/o/d/r=%b expected %b", tag, idx, got, e);
      end
      idx++;
    end
  end

  task automatic push(input logic v, input logic ob, input logic d, input logic r);
    exp_t e;
    e = {v, ob, d, r};
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reference model for a complete transmission: bursts, gaps, done, ready.
  task automatic push_tx(input logic [PW-1:0] pat, input int reps, input int gp);
    for (int r = 0; r < reps; r++) begin
      for (int b = PW - 1; b >= 0; b--) push(1'b1, pat[b], 1'b0, 1'b0);
      if (r < reps - 1) repeat (gp) push(1'b0, 1'b0, 1'b0, 1'b0);
    end
    push(1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic begin_test(input string t);
    tag = t;
    idx = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb_q.size() == 0)
    else begin
      errors++;
      $error("FAIL %s drain observed %0d entries left expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic kick(input logic [PW-1:0] pat, input int reps, input int gp);
    @(negedge clk);
    pattern  = pat;
    repeat_n = CW'(reps);
    gap      = GW'(gp);
    start    = 1'b1;
    push_tx(pat, reps, gp);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap      = '0;
    repeat (3) @(negedge clk);
    checks++;
    assert ({o_valid, o, done, ready} === 4'b0001)
    else begin
      errors++;
      $error("FAIL reset_state observed v/o/d/r=%b expected 0001", {o_valid, o, done, ready});
    end

    begin_test("post_reset");
    rst = 1'b0;
    push_idle(2);
    drain();

    begin_test("single_10110");
    kick(5'b10110, 1, 0);
    drain();

    begin_test("rep3_gap2");
    kick(5'b11001, 3, 2);
    drain();

    begin_test("rep2_gap0");
    kick(5'b11001, 2, 0);
    drain();

    // Abort while the third bit is on o.
    begin_test("abort_bit3");
    @(negedge clk);
    pattern  = 5'b10110;
    repeat_n = CW'(2);
    gap      = GW'(1);
    start    = 1'b1;
    push(1'b1, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0);
    push_idle(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    begin_test("rep0");
    kick(5'b11111, 0, 3);
    drain();

    // A start request while busy must not disturb the transmission.
    begin_test("busy_start");
    @(negedge clk);
    pattern  = 5'b10011;
    repeat_n = CW'(2);
    gap      = GW'(1);
    start    = 1'b1;
    push_tx(5'b10011, 2, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pattern  = 5'b01111;
    repeat_n = CW'(5);
    gap      = GW'(0);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during the first gap cycle.
    begin_test("rst_mid_gap");
    @(negedge clk);
    pattern  = 5'b11001;
    repeat_n = CW'(3);
    gap      = GW'(3);
    start    = 1'b1;
    for (int b = PW - 1; b >= 0; b--) push(1'b1, pattern[b], 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(4);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();

    begin_test("start_and_abort");
    @(negedge clk);
    pattern  = 5'b10101;
    repeat_n = CW'(1);
    gap      = GW'(0);
    start    = 1'b1;
    abort    = 1'b1;
    push_idle(6);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    drain();

    // Abort in DONE: the pulse still appears, and the return to IDLE is unchanged.
    begin_test("abort_in_done");
    @(negedge clk);
    pattern  = 5'b01101;
    repeat_n = CW'(1);
    gap      = GW'(0);
    start    = 1'b1;
    push_tx(5'b01101, 1, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain();

    begin_test("rep15_gap0");
    kick(5'b10110, 15, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
